// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port among PTW, data (D) and fetch (I).
// One transaction in flight; each requester stays stalled until its done pulse.
// Build option: define ARB_ROUND_ROBIN_EN to alternate D/I priority (PTW stays first).
module mem_port_arbiter #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ptw_ren,
  input  logic [ADDR_W-1:0]   ptw_addr,
  output logic [DATA_W-1:0]   ptw_rdata,
  output logic                ptw_stall,
  input  logic                d_req,
  input  logic                d_we,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  input  logic [DATA_W/8-1:0] d_wmask,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                d_stall,
  input  logic                i_req,
  input  logic [ADDR_W-1:0]   i_addr,
  output logic [DATA_W-1:0]   i_rdata,
  output logic                i_stall,
  output logic                mem_req,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_wmask,
  input  logic                mem_ack,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic [1:0]          owner
);
  localparam int MASK_W = DATA_W / 8;

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;
  typedef enum logic [1:0] {OWN_NONE = 2'd0, OWN_PTW = 2'd1, OWN_D = 2'd2, OWN_I = 2'd3} own_t;
  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [MASK_W-1:0] wmask;
  } mem_cmd_t;

  state_t   state, state_nxt;
  own_t     grant;
  mem_cmd_t cmd_nxt;
  logic     own_live;
  logic     ptw_done, d_done, i_done;
`ifdef ARB_ROUND_ROBIN_EN
  logic     last_i;  // 1: I won the most recent D/I grant
`endif

  // Done pulses are ignored while reset is held so stall follows the request
  assign ptw_stall = ptw_ren & ~(ptw_done & ~rst);
  assign d_stall   = d_req   & ~(d_done   & ~rst);
  assign i_stall   = i_req   & ~(i_done   & ~rst);

  // Winner selection, winner's command, owner liveness and next state
  always_comb begin
    state_nxt = state;
    grant     = OWN_NONE;
    cmd_nxt   = '0;
    own_live  = 1'b0;
    if (ptw_ren) grant = OWN_PTW;
`ifdef ARB_ROUND_ROBIN_EN
    else if (d_req && (!i_req || last_i)) grant = OWN_D;
    else if (i_req) grant = OWN_I;
`else
    else if (d_req) grant = OWN_D;
    else if (i_req) grant = OWN_I;
`endif
    case (grant)
      OWN_PTW: cmd_nxt.addr = ptw_addr;
      OWN_D: begin
        cmd_nxt.we    = d_we;
        cmd_nxt.addr  = d_addr;
        cmd_nxt.wdata = d_wdata;
        cmd_nxt.wmask = d_we ? d_wmask : '0;
      end
      OWN_I:   cmd_nxt.addr = i_addr;
      default: ;
    endcase
    case (owner)
      OWN_PTW: own_live = ptw_ren;
      OWN_D:   own_live = d_req;
      OWN_I:   own_live = i_req;
      default: own_live = 1'b0;
    endcase
    case (state)
      IDLE:    if (grant != OWN_NONE) state_nxt = BUSY;
      BUSY:    if (mem_ack) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Memory command latch, read-data capture and done pulses
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_wmask <= '0;
      owner     <= OWN_NONE;
      ptw_rdata <= '0;
      d_rdata   <= '0;
      i_rdata   <= '0;
      ptw_done  <= 1'b0;
      d_done    <= 1'b0;
      i_done    <= 1'b0;
    end else begin
      case (state)
        IDLE: if (grant != OWN_NONE) begin
          mem_req   <= 1'b1;
          mem_we    <= cmd_nxt.we;
          mem_addr  <= cmd_nxt.addr;
          mem_wdata <= cmd_nxt.wdata;
          mem_wmask <= cmd_nxt.wmask;
          owner     <= grant;
        end
        BUSY: if (mem_ack) begin
          mem_req <= 1'b0;
          // An owner that dropped its request gets neither data nor done
          if (own_live) begin
            case (owner)
              OWN_PTW: begin ptw_rdata <= mem_rdata; ptw_done <= 1'b1; end
              OWN_D: begin
                if (!mem_we) d_rdata <= mem_rdata;
                d_done <= 1'b1;
              end
              OWN_I:   begin i_rdata <= mem_rdata; i_done <= 1'b1; end
              default: ;
            endcase
          end
        end
        RESP: begin
          ptw_done <= 1'b0;
          d_done   <= 1'b0;
          i_done   <= 1'b0;
          owner    <= OWN_NONE;
        end
        default: ;
      endcase
    end
  end

`ifdef ARB_ROUND_ROBIN_EN
  // Remember which of D/I won last so the other goes first next time
  always_ff @(posedge clk) begin
    if (rst) last_i <= 1'b1;
    else if (state == IDLE && grant == OWN_D) last_i <= 1'b0;
    else if (state == IDLE && grant == OWN_I) last_i <= 1'b1;
  end
`endif
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Testbench for mem_port_arbiter: directed scenarios, then a randomized run
// checked against a transaction-level model of the arbitration rules.
module tb_mem_port_arbiter;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ptw_ren = 0, d_req = 0, d_we = 0, i_req = 0, mem_ack = 0;
  logic [63:0] ptw_addr = 0, d_addr = 0, d_wdata = 0, i_addr = 0, mem_rdata = 0;
  logic [7:0]  d_wmask = 0;
  logic [63:0] ptw_rdata, d_rdata, i_rdata, mem_addr, mem_wdata;
  logic        ptw_stall, d_stall, i_stall, mem_req, mem_we;
  logic [7:0]  mem_wmask;
  logic [1:0]  owner;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(64), .DATA_W(64)) dut (
    .clk(clk), .rst(rst),
    .ptw_ren(ptw_ren), .ptw_addr(ptw_addr), .ptw_rdata(ptw_rdata), .ptw_stall(ptw_stall),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_wmask(d_wmask),
    .d_rdata(d_rdata), .d_stall(d_stall),
    .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_stall(i_stall),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wmask(mem_wmask), .mem_ack(mem_ack), .mem_rdata(mem_rdata), .owner(owner)
  );

  int errs = 0, checks = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Called in the first cycle mem_req is high; returns in the response cycle
  task automatic serve(input int lat, input logic [63:0] data);
    repeat (lat) tick();
    mem_ack = 1'b1; mem_rdata = data;
    tick();
    mem_ack = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1; tick(); tick(); rst = 1'b0;
  endtask

  // Transaction-level model state for the random run
  logic [2:0]  act;
  logic [63:0] r_addr [3];
  logic        r_we   [3];
  logic [63:0] r_wdata[3];
  logic [7:0]  r_wmask[3];
  logic [63:0] m_rdata[3];
  int          exp_grant, cur, lat_left, resp_idx, g;
  bit          txn, can_sample, rr_last_i;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset values, stall follows request while reset is held
    ptw_ren = 1'b1;
    tick(); tick();
    chk("rst_mem_req", mem_req, 0);
    chk("rst_owner", owner, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_wmask", mem_wmask, 0);
    chk("rst_ptw_rdata", ptw_rdata, 0);
    chk("rst_d_rdata", d_rdata, 0);
    chk("rst_ptw_stall", ptw_stall, 1);
    chk("rst_d_stall", d_stall, 0);
    ptw_ren = 1'b0; rst = 1'b0;
    tick();
    chk("idle_mem_req", mem_req, 0);

    // PTW only
    ptw_addr = 64'h8000_1008; ptw_ren = 1'b1;
    tick();
    chk("ptw_mem_req", mem_req, 1);
    chk("ptw_mem_addr", mem_addr, 64'h8000_1008);
    chk("ptw_mem_we", mem_we, 0);
    chk("ptw_owner", owner, 1);
    chk("ptw_stall_busy", ptw_stall, 1);
    serve(2, 64'h0000_0000_2000_0C01);
    chk("ptw_stall_resp", ptw_stall, 0);
    chk("ptw_rdata", ptw_rdata, 64'h2000_0C01);
    chk("ptw_mem_req_resp", mem_req, 0);
    tick();
    chk("ptw_stall_after", ptw_stall, 1);
    chk("ptw_owner_idle", owner, 0);
    ptw_ren = 1'b0;
    tick();
    chk("ptw_no_regrant", mem_req, 0);

    // All three at once: PTW, then D, then I
    ptw_ren = 1; ptw_addr = 64'h1000; d_req = 1; d_we = 0; d_addr = 64'h2000;
    i_req = 1; i_addr = 64'h3000;
    tick();
    chk("all_owner_p", owner, 1);
    chk("all_addr_p", mem_addr, 64'h1000);
    chk("all_d_stall_p", d_stall, 1);
    serve(1, 64'hA1);
    chk("all_ptw_stall", ptw_stall, 0);
    chk("all_d_stall_r1", d_stall, 1);
    chk("all_i_stall_r1", i_stall, 1);
    chk("all_ptw_rdata", ptw_rdata, 64'hA1);
    ptw_ren = 0;
    tick();
    chk("all_idle_req", mem_req, 0);
    chk("all_i_stall_idle", i_stall, 1);
    tick();
    chk("all_owner_d", owner, 2);
    chk("all_addr_d", mem_addr, 64'h2000);
    serve(0, 64'hB2);
    chk("all_d_stall", d_stall, 0);
    chk("all_i_stall_r2", i_stall, 1);
    chk("all_d_rdata", d_rdata, 64'hB2);
    d_req = 0;
    tick(); tick();
    chk("all_owner_i", owner, 3);
    chk("all_addr_i", mem_addr, 64'h3000);
    chk("all_i_stall_busy", i_stall, 1);
    serve(3, 64'hC3);
    chk("all_i_stall", i_stall, 0);
    chk("all_i_rdata", i_rdata, 64'hC3);
    chk("all_ptw_keep", ptw_rdata, 64'hA1);
    i_req = 0;
    tick();

    // D store
    d_req = 1; d_we = 1; d_addr = 64'h100; d_wdata = 64'hDEAD_BEEF; d_wmask = 8'h0F;
    tick();
    chk("st_owner", owner, 2);
    chk("st_we", mem_we, 1);
    chk("st_wmask", mem_wmask, 8'h0F);
    chk("st_wdata", mem_wdata, 64'hDEAD_BEEF);
    chk("st_addr", mem_addr, 64'h100);
    tick();
    chk("st_we_hold", mem_we, 1);
    chk("st_wmask_hold", mem_wmask, 8'h0F);
    chk("st_req_hold", mem_req, 1);
    chk("st_stall_busy", d_stall, 1);
    mem_ack = 1; mem_rdata = 64'h1234;
    tick();
    mem_ack = 0;
    chk("st_stall_resp", d_stall, 0);
    chk("st_rdata_keep", d_rdata, 64'hB2);
    tick();
    chk("st_stall_after", d_stall, 1);
    chk("st_owner_idle", owner, 0);
    d_req = 0; d_we = 0; d_wmask = 0;
    tick();

    // Abort: PTW drops its request while BUSY, pending I goes next
    ptw_ren = 1; ptw_addr = 64'h4000; i_req = 1; i_addr = 64'h5000;
    tick();
    chk("ab_owner", owner, 1);
    tick();
    ptw_ren = 0;
    tick();
    chk("ab_req_held", mem_req, 1);
    mem_ack = 1; mem_rdata = 64'h55;
    tick();
    mem_ack = 0;
    chk("ab_rdata_keep", ptw_rdata, 64'hA1);
    chk("ab_req_resp", mem_req, 0);
    chk("ab_i_stall", i_stall, 1);
    tick();
    chk("ab_owner_idle", owner, 0);
    tick();
    chk("ab_owner_i", owner, 3);
    chk("ab_addr_i", mem_addr, 64'h5000);
    serve(0, 64'hD4);
    chk("ab_i_stall_done", i_stall, 0);
    chk("ab_i_rdata", i_rdata, 64'hD4);
    chk("ab_ptw_keep", ptw_rdata, 64'hA1);
    i_req = 0;
    tick();

    // Reset while BUSY, held request granted again afterwards
    d_req = 1; d_we = 0; d_addr = 64'h200;
    tick();
    chk("rb_req", mem_req, 1);
    rst = 1;
    tick();
    chk("rb_req_rst", mem_req, 0);
    chk("rb_owner_rst", owner, 0);
    chk("rb_stall_rst", d_stall, 1);
    chk("rb_rdata_rst", d_rdata, 0);
    rst = 0;
    tick();
    chk("rb_regrant", mem_req, 1);
    chk("rb_owner", owner, 2);
    chk("rb_addr", mem_addr, 64'h200);
    serve(1, 64'hE5);
    chk("rb_stall", d_stall, 0);
    chk("rb_rdata", d_rdata, 64'hE5);
    d_req = 0;
    tick();

    // D and I held continuously
    do_reset();
    d_req = 1; d_we = 0; d_addr = 64'h600; i_req = 1; i_addr = 64'h700;
    for (int k = 0; k < 4; k++) begin
      tick();
`ifdef ARB_ROUND_ROBIN_EN
      chk("rr_owner", owner, (k % 2 == 0) ? 2 : 3);
`else
      chk("fp_owner", owner, 2);
`endif
      serve(0, 64'(k));
      tick();
    end
    d_req = 0; i_req = 0;
    tick();

    // Randomized run against the model
    do_reset();
    act = '0; exp_grant = -1; cur = 0; lat_left = 0; resp_idx = -1;
    txn = 0; can_sample = 1; rr_last_i = 1;
    for (int k = 0; k < 3; k++) begin
      r_addr[k] = 0; r_we[k] = 0; r_wdata[k] = 0; r_wmask[k] = 0; m_rdata[k] = 0;
    end
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (exp_grant >= 0) begin
        txn = 1; cur = exp_grant; lat_left = $urandom_range(0, 3); exp_grant = -1;
      end
      if (txn) begin
        chk("r_mem_req", mem_req, 1);
        chk("r_owner", owner, 64'(cur + 1));
        chk("r_addr", mem_addr, r_addr[cur]);
        chk("r_we", mem_we, r_we[cur]);
        chk("r_wmask", mem_wmask, r_we[cur] ? r_wmask[cur] : 8'h0);
        if (r_we[cur]) chk("r_wdata", mem_wdata, r_wdata[cur]);
      end else begin
        chk("r_mem_req_off", mem_req, 0);
        if (resp_idx >= 0) chk("r_owner_resp", owner, 64'(resp_idx + 1));
        else               chk("r_owner_off", owner, 0);
      end
      chk("r_ptw_stall", ptw_stall, act[0] && resp_idx != 0);
      chk("r_d_stall", d_stall, act[1] && resp_idx != 1);
      chk("r_i_stall", i_stall, act[2] && resp_idx != 2);
      chk("r_ptw_rdata", ptw_rdata, m_rdata[0]);
      chk("r_d_rdata", d_rdata, m_rdata[1]);
      chk("r_i_rdata", i_rdata, m_rdata[2]);

      // Requesters: the completed one drops, idle ones may raise a request
      if (resp_idx >= 0) act[resp_idx] = 1'b0;
      for (int k = 0; k < 3; k++) begin
        if (!act[k] && k != resp_idx && $urandom_range(0, 3) == 0) begin
          act[k] = 1'b1;
          r_addr[k] = {$urandom, $urandom};
          r_we[k] = (k == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
          r_wdata[k] = {$urandom, $urandom};
          r_wmask[k] = 8'($urandom_range(0, 255));
        end
      end
      ptw_ren = act[0]; ptw_addr = r_addr[0];
      d_req = act[1]; d_we = r_we[1]; d_addr = r_addr[1];
      d_wdata = r_wdata[1]; d_wmask = r_wmask[1];
      i_req = act[2]; i_addr = r_addr[2];

      // Arbiter samples only when free; a response cycle frees it for the next one
      if (can_sample && act != 3'b000) begin
        if (act[0]) g = 0;
`ifdef ARB_ROUND_ROBIN_EN
        else if (act[1] && act[2]) g = rr_last_i ? 1 : 2;
`endif
        else if (act[1]) g = 1;
        else g = 2;
        if (g > 0) rr_last_i = (g == 2);
        exp_grant = g;
        can_sample = 0;
      end
      if (resp_idx >= 0) can_sample = 1;

      // Memory: ack the live transaction after its latency, stray acks otherwise
      resp_idx = -1;
      mem_ack = 1'b0;
      if (txn) begin
        if (lat_left == 0) begin
          mem_ack = 1'b1; mem_rdata = {$urandom, $urandom};
          if (!r_we[cur]) m_rdata[cur] = mem_rdata;
          resp_idx = cur; txn = 0;
        end else lat_left--;
      end else if ($urandom_range(0, 4) == 0) begin
        mem_ack = 1'b1; mem_rdata = {$urandom, $urandom};
      end
      tick();
    end
    mem_ack = 0; ptw_ren = 0; d_req = 0; i_req = 0;
    tick();

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
